counter_sequencer: RTL and testbench
====================================

Name: counter_sequencer

Overview:
Command-driven controller that sequences an external loadable up-counter (clk/load/enable/load_val/q interface). It accepts a start value and an increment count over a valid/ready handshake, then programs and runs the counter. It either stops (one-shot) or reloads repeatedly (auto-reload) and checks the final counter value against the expected result. It sits between the control/CSR logic and the counter datapath, and is the only block that drives the counter's load and enable inputs.

Parameters:
WIDTH, 8, counter/value width in bits; all arithmetic is modulo 2^WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  block idle, can accept a command
cmd_start  input  WIDTH  value loaded into the counter
cmd_count  input  WIDTH  number of increments per run (0 allowed)
cmd_reload  input  1  0 = one-shot, 1 = auto-reload until abort
pause  input  1  level; holds the counter (no increment) while high in RUN
abort  input  1  pulse/level; terminates any active run
ctr_load  output  1  to counter load
ctr_enable  output  1  to counter enable
ctr_load_val  output  WIDTH  to counter load_val
ctr_q  input  WIDTH  counter output q
busy  output  1  high in LOAD/RUN/DONE
done  output  1  1-cycle pulse, one-shot run completed
reload_pulse  output  1  1-cycle pulse each auto-reload
aborted  output  1  1-cycle pulse, run aborted
result  output  WIDTH  ctr_q captured at completion
err  output  1  sticky; result != expected, cleared on next accepted command

Behaviour:
- One clock, one reset: clk and rst. Reset is synchronous and active-high; the clock is the single rising-edge clk.
- rst sampled high at an edge: state=IDLE, remaining=0, exp=0, ctr_load_val=0, result=0, err=0, done/reload_pulse/aborted=0. rst overrides all other inputs.
- FSM states: IDLE, LOAD, RUN, DONE.
- Combinational outputs:
  - cmd_ready = (state==IDLE)
  - ctr_load = (state==LOAD)
  - ctr_enable = (state==RUN) && !pause && !abort
  - busy = (state!=IDLE)
- Every other output is registered.
- IDLE: accept when cmd_valid && cmd_ready at an edge. Latch ctr_load_val=cmd_start, cnt_cfg=cmd_count, mode=cmd_reload. Set remaining=cmd_count, exp=cmd_start+cmd_count (mod 2^WIDTH), err=0. Go to LOAD.
- LOAD (1 cycle; the counter loads at the closing edge):
  - remaining==0 and mode==0: go to DONE.
  - remaining==0 and mode==1: stay in LOAD, pulsing reload_pulse each cycle (degenerate continuous reload).
  - otherwise: go to RUN.
- RUN: on each edge with ctr_enable=1, remaining -= 1. When remaining==1 and ctr_enable=1:
  - mode==0: go to DONE.
  - mode==1: go to LOAD, set remaining=cnt_cfg, pulse reload_pulse on the next cycle.
- Pause: no increment and no decrement; the state is held.
- DONE (1 cycle): at the closing edge, result<=ctr_q, err<=(ctr_q!=exp), done pulse high for the following cycle, then IDLE.
- Latency: with no pause, one-shot accept-to-done = cmd_count+2 edges (LOAD + count RUN + DONE).
- Abort (sampled at an edge in LOAD or RUN): go to IDLE, aborted=1 for one cycle, no done, result unchanged. Abort wins over a simultaneous final increment, because ctr_enable is forced low by abort. Abort in IDLE or DONE is ignored.
- cmd_valid while busy is ignored; there is no queueing.
- The counter wraps naturally: 0xFF+1 = 0x00; exp uses the same modular sum.

Test Plan:
- Reset, then cmd start=0x3C count=5 reload=0 -> 1 cycle ctr_load with ctr_load_val=0x3C, then 5 cycles ctr_enable, then DONE; done pulses once, result=0x41, err=0, cmd_ready=1 on the next cycle.
- start=0xFE count=4 -> counter sequence FE,FF,00,01,02; result=0x02, err=0.
- start=0x10 count=3, pause high for 2 cycles after the first increment -> ctr_enable low for exactly those cycles; done at accept+7 edges, result=0x13.
- start=0x00 count=3 reload=1 -> q cycles 00,01,02,03 then reload to 00; reload_pulse every 4 cycles; abort mid-RUN -> IDLE next edge, aborted pulse, done never asserted.
- count=0 reload=0 start=0x55 -> LOAD then DONE with zero ctr_enable cycles; result=0x55. Second case: bench counter model stuck at 0x00 with start=0x20 count=2 -> err=1, which clears on the next accepted command.
- rst asserted mid-RUN (count=10) -> at the next edge all registered outputs are 0, ctr_enable/ctr_load=0, cmd_ready=1 after rst deasserts. rst pulse that does not span an edge -> no effect.

Source files
------------

// File: rtl/counter_sequencer.sv
// Command-driven sequencer for an external loadable up-counter: loads a start value,
// runs a fixed number of increments (one-shot or auto-reload) and checks the final value.
module counter_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_count,
    input  logic             cmd_reload,
    input  logic             pause,
    input  logic             abort,
    output logic             ctr_load,
    output logic             ctr_enable,
    output logic [WIDTH-1:0] ctr_load_val,
    input  logic [WIDTH-1:0] ctr_q,
    output logic             busy,
    output logic             done,
    output logic             reload_pulse,
    output logic             aborted,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] remaining;
    logic [WIDTH-1:0] remaining_next;
    logic [WIDTH-1:0] cnt_cfg;
    logic [WIDTH-1:0] exp_val;
    logic             mode;
    logic             reload_next;
    logic             aborted_next;
    logic             accept;

    assign cmd_ready  = (state == IDLE);
    assign ctr_load   = (state == LOAD);
    assign ctr_enable = (state == RUN) && !pause && !abort;
    assign busy       = (state != IDLE);
    assign accept     = cmd_valid && cmd_ready;

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        reload_next    = 1'b0;
        aborted_next   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next     = LOAD;
                    remaining_next = cmd_count;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next   = IDLE;
                    aborted_next = 1'b1;
                end else if (remaining == '0) begin
                    // zero-length auto-reload keeps reloading without ever running
                    if (mode) reload_next = 1'b1;
                    else      state_next  = DONE;
                end else begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next   = IDLE;
                    aborted_next = 1'b1;
                end else if (ctr_enable) begin
                    remaining_next = remaining - WIDTH'(1);
                    if (remaining == WIDTH'(1)) begin
                        if (mode) begin
                            state_next     = LOAD;
                            remaining_next = cnt_cfg;
                            reload_next    = 1'b1;
                        end else begin
                            state_next = DONE;
                        end
                    end
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining    <= '0;
            cnt_cfg      <= '0;
            exp_val      <= '0;
            mode         <= 1'b0;
            ctr_load_val <= '0;
            result       <= '0;
            err          <= 1'b0;
            done         <= 1'b0;
            reload_pulse <= 1'b0;
            aborted      <= 1'b0;
        end else begin
            remaining    <= remaining_next;
            reload_pulse <= reload_next;
            aborted      <= aborted_next;
            done         <= (state == DONE);
            if (accept) begin
                ctr_load_val <= cmd_start;
                cnt_cfg      <= cmd_count;
                mode         <= cmd_reload;
                exp_val      <= cmd_start + cmd_count;
                err          <= 1'b0;
            end
            if (state == DONE) begin
                result <= ctr_q;
                err    <= (ctr_q != exp_val);
            end
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: behavioural counter plus a run-level reference model
// (load cycle, count unpaused increments, one check cycle) driven by directed and random commands.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_start;
    logic [7:0] cmd_count;
    logic       cmd_reload;
    logic       pause;
    logic       abort;
    logic       ctr_load;
    logic       ctr_enable;
    logic [7:0] ctr_load_val;
    logic [7:0] ctr_q;
    logic       busy;
    logic       done;
    logic       reload_pulse;
    logic       aborted;
    logic [7:0] result;
    logic       err;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_result = 8'h00;
    logic       m_err = 1'b0;
    bit         stuck = 1'b0;
    logic [7:0] q = 8'h00;

    always #5 clk = ~clk;

    counter_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_count(cmd_count), .cmd_reload(cmd_reload),
        .pause(pause), .abort(abort), .ctr_load(ctr_load), .ctr_enable(ctr_enable),
        .ctr_load_val(ctr_load_val), .ctr_q(ctr_q), .busy(busy), .done(done),
        .reload_pulse(reload_pulse), .aborted(aborted), .result(result), .err(err)
    );

    // external counter; "stuck" models a broken datapath frozen at zero
    always @(posedge clk) begin
        if (stuck)           q <= 8'h00;
        else if (ctr_load)   q <= ctr_load_val;
        else if (ctr_enable) q <= q + 8'd1;
    end
    assign ctr_q = q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic oneshot(input logic [7:0] start, input logic [7:0] cnt, input logic [31:0] pmask,
                           input int abort_k, input int glitch_k, input bit stk);
        int         k;
        int         incs;
        bit         fin;
        bit         exp_en;
        logic [7:0] sum;
        logic [7:0] qexp;
        sum   = start + cnt;
        stuck = stk;
        chk("idle_err", err, m_err);
        chk("idle_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_start = start; cmd_count = cnt; cmd_reload = 1'b0;
        cyc();
        m_err = 1'b0;
        chk("accept_err_clr", err, 0);
        k = 0; incs = 0; fin = 0;
        while (!fin) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_start = 8'($urandom);
            cmd_count = 8'($urandom);
            pause     = (k < 32) ? pmask[k] : 1'b0;
            abort     = (k == abort_k);
            #1;
            exp_en = (k >= 1) && (incs < int'(cnt)) && !pause && !abort;
            chk("ctr_load", ctr_load, (k == 0));
            chk("ctr_enable", ctr_enable, exp_en);
            chk("run_busy", busy, 1);
            chk("run_ready", cmd_ready, 0);
            chk("run_done", done, 0);
            chk("run_reload_pulse", reload_pulse, 0);
            chk("ctr_load_val", ctr_load_val, start);
            if (k >= 1 && !stk) begin
                qexp = start + 8'(incs);
                chk("ctr_q", ctr_q, qexp);
            end
            if (abort) begin
                cyc();
                abort = 1'b0; pause = 1'b0; cmd_valid = 1'b0;
                #1;
                chk("abort_pulse", aborted, 1);
                chk("abort_ready", cmd_ready, 1);
                chk("abort_no_done", done, 0);
                chk("abort_result", result, m_result);
                cyc();
                chk("abort_pulse_end", aborted, 0);
                chk("abort_no_done2", done, 0);
                stuck = 1'b0;
                return;
            end
            if (k == glitch_k) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
            if (k >= 1 && incs == int'(cnt)) fin = 1;
            if (exp_en) incs++;
            cyc();
            k++;
        end
        cmd_valid = 1'b0; pause = 1'b0;
        m_result = stk ? 8'h00 : sum;
        m_err    = (m_result != sum);
        #1;
        chk("done_pulse", done, 1);
        chk("result", result, m_result);
        chk("err", err, m_err);
        chk("done_ready", cmd_ready, 1);
        chk("done_busy", busy, 0);
        cyc();
        chk("done_pulse_end", done, 0);
        stuck = 1'b0;
    endtask

    task automatic reload_run(input logic [7:0] start, input logic [7:0] cnt, input int n_abort);
        int         c;
        bit         exp_load;
        logic [7:0] qexp;
        c = int'(cnt) + 1;
        cmd_valid = 1'b1; cmd_start = start; cmd_count = cnt; cmd_reload = 1'b1;
        cyc();
        cmd_valid = 1'b0; cmd_reload = 1'b0; m_err = 1'b0;
        for (int k = 0; k <= n_abort; k++) begin
            abort = (k == n_abort);
            pause = 1'b0;
            #1;
            exp_load = ((k % c) == 0);
            chk("rl_load", ctr_load, exp_load);
            chk("rl_enable", ctr_enable, !exp_load && !abort);
            chk("rl_pulse", reload_pulse, (k > 0) && exp_load);
            chk("rl_done", done, 0);
            chk("rl_busy", busy, 1);
            if (k >= 1) begin
                qexp = start + 8'((k - 1) % c);
                chk("rl_ctr_q", ctr_q, qexp);
            end
            cyc();
        end
        abort = 1'b0;
        #1;
        chk("rl_aborted", aborted, 1);
        chk("rl_abort_ready", cmd_ready, 1);
        chk("rl_abort_no_done", done, 0);
        chk("rl_abort_pulse_clr", reload_pulse, 0);
        chk("rl_abort_result", result, m_result);
        chk("rl_abort_err", err, 0);
        cyc();
        chk("rl_aborted_end", aborted, 0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_start = '0; cmd_count = '0; cmd_reload = 1'b0;
        pause = 1'b0; abort = 1'b0;
        repeat (2) cyc();
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_load", ctr_load, 0);
        chk("rst_enable", ctr_enable, 0);
        chk("rst_load_val", ctr_load_val, 0);
        chk("rst_result", result, 0);
        chk("rst_err", err, 0);
        chk("rst_flags", {done, reload_pulse, aborted}, 0);
        rst = 1'b0;
        cyc();

        abort = 1'b1;
        cyc();
        chk("idle_abort_ignored", aborted, 0);
        chk("idle_abort_ready", cmd_ready, 1);
        abort = 1'b0;

        oneshot(8'h3C, 8'd5, 32'h0, -1, -1, 1'b0);
        oneshot(8'hFE, 8'd4, 32'h0, -1, -1, 1'b0);
        oneshot(8'h10, 8'd3, 32'hC, -1, -1, 1'b0);
        reload_run(8'h00, 8'd3, 10);
        oneshot(8'h55, 8'd0, 32'h0, -1, -1, 1'b0);
        oneshot(8'h20, 8'd2, 32'h0, -1, -1, 1'b1);
        cyc();
        oneshot(8'h07, 8'd1, 32'h0, -1, -1, 1'b0);
        oneshot(8'h30, 8'd2, 32'h0, 2, -1, 1'b0);
        oneshot(8'h31, 8'd4, 32'h0, 0, -1, 1'b0);
        reload_run(8'hA0, 8'd0, 3);
        oneshot(8'h40, 8'd6, 32'h0, -1, 3, 1'b0);

        // synchronous reset in the middle of a run
        cmd_valid = 1'b1; cmd_start = 8'h77; cmd_count = 8'd10; cmd_reload = 1'b0;
        cyc();
        cmd_valid = 1'b0;
        repeat (4) cyc();
        chk("mid_enable", ctr_enable, 1);
        rst = 1'b1;
        cyc();
        chk("mid_rst_load", ctr_load, 0);
        chk("mid_rst_enable", ctr_enable, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_load_val", ctr_load_val, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_flags", {done, reload_pulse, aborted}, 0);
        rst = 1'b0;
        cyc();
        chk("mid_rst_ready", cmd_ready, 1);
        m_result = 8'h00; m_err = 1'b0;

        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                reload_run(8'($urandom), 8'($urandom_range(0, 5)), int'($urandom_range(0, 15)));
            end else begin
                int c;
                int ab;
                c  = int'($urandom_range(0, 12));
                ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, c)) : -1;
                oneshot(8'($urandom), 8'(c), $urandom & $urandom, ab, -1, ($urandom_range(0, 7) == 0));
            end
            repeat ($urandom_range(0, 2)) cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
